// File: rtl/wb_arbiter2_if.sv
// wb_arbiter2_if: two-master/one-slave Wishbone bundle; the arbiter takes the master modport
// because it masters the shared RAM port, and the surrounding logic takes the slave modport.
interface wb_arbiter2_if #(parameter int AW = 32);
    logic          i_m0_cyc, i_m1_cyc;
    logic [3:0]    i_m0_stb, i_m1_stb;
    logic          i_m0_we, i_m1_we;
    logic [AW-1:0] i_m0_addr, i_m1_addr;
    logic [31:0]   i_m0_dat, i_m1_dat;
    logic [31:0]   o_m0_dat, o_m1_dat;
    logic          o_m0_ack, o_m1_ack;
    logic          o_m0_err, o_m1_err;
    logic          o_s_cyc;
    logic [3:0]    o_s_stb;
    logic          o_s_we;
    logic [AW-1:0] o_s_addr;
    logic [31:0]   o_s_dat;
    logic [31:0]   i_s_dat;
    logic          i_s_ack;
    logic          o_timeout;
    modport master (
        input  i_m0_cyc, i_m1_cyc, i_m0_stb, i_m1_stb, i_m0_we, i_m1_we,
               i_m0_addr, i_m1_addr, i_m0_dat, i_m1_dat, i_s_dat, i_s_ack,
        output o_m0_dat, o_m1_dat, o_m0_ack, o_m1_ack, o_m0_err, o_m1_err,
               o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_dat, o_timeout
    );
    modport slave (
        output i_m0_cyc, i_m1_cyc, i_m0_stb, i_m1_stb, i_m0_we, i_m1_we,
               i_m0_addr, i_m1_addr, i_m0_dat, i_m1_dat, i_s_dat, i_s_ack,
        input  o_m0_dat, o_m1_dat, o_m0_ack, o_m1_ack, o_m0_err, o_m1_err,
               o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_dat, o_timeout
    );
endinterface

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: round-robin two-master Wishbone arbiter with per-access timeout and sticky timeout flag.
module wb_arbiter2 #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int AW = 32
) (
    input logic i_clk,
    input logic i_reset,
    wb_arbiter2_if.master bus
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1, DROP} state_t;
    state_t state, state_n;
    logic last, last_n, timeout;
    logic [7:0] cnt, cnt_n;
    logic own, cur_cyc, oth_cyc, tmo;
    logic [3:0] cur_stb;
    // last always names the current owner while in OWN*/DROP, so it doubles as the mux select
    assign own     = (state == OWN0) || (state == OWN1);
    assign cur_cyc = last ? bus.i_m1_cyc : bus.i_m0_cyc;
    assign oth_cyc = last ? bus.i_m0_cyc : bus.i_m1_cyc;
    assign cur_stb = last ? bus.i_m1_stb : bus.i_m0_stb;
    assign tmo     = own && cur_cyc && !bus.i_s_ack && cnt == 8'(TIMEOUT_CYCLES);
    assign bus.o_s_cyc   = own && cur_cyc;
    assign bus.o_s_stb   = own ? cur_stb : 4'h0;
    assign bus.o_s_we    = own && (last ? bus.i_m1_we : bus.i_m0_we);
    assign bus.o_s_addr  = own ? (last ? bus.i_m1_addr : bus.i_m0_addr) : AW'(0);
    assign bus.o_s_dat   = own ? (last ? bus.i_m1_dat : bus.i_m0_dat) : 32'h0;
    assign bus.o_m0_ack  = own && !last && bus.i_s_ack;
    assign bus.o_m1_ack  = own && last && bus.i_s_ack;
    assign bus.o_m0_dat  = (own && !last) ? bus.i_s_dat : 32'h0;
    assign bus.o_m1_dat  = (own && last) ? bus.i_s_dat : 32'h0;
    assign bus.o_m0_err  = tmo && !last;
    assign bus.o_m1_err  = tmo && last;
    assign bus.o_timeout = timeout;
    always_ff @(posedge i_clk or negedge i_reset)
        if (!i_reset) begin
            state   <= IDLE;
            last    <= 1'b1;
            cnt     <= 8'h0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            last    <= last_n;
            cnt     <= cnt_n;
            timeout <= timeout || tmo;
        end
    always_comb begin
        state_n = state;
        last_n  = last;
        cnt_n   = cnt;
        case (state)
            IDLE:
                if (bus.i_m0_cyc && (!bus.i_m1_cyc || last)) begin
                    state_n = OWN0;
                    last_n  = 1'b0;
                    cnt_n   = 8'h0;
                end else if (bus.i_m1_cyc) begin
                    state_n = OWN1;
                    last_n  = 1'b1;
                    cnt_n   = 8'h0;
                end
            OWN0, OWN1:
                if (tmo)
                    state_n = DROP;
                else if (!cur_cyc) begin
                    state_n = oth_cyc ? (last ? OWN0 : OWN1) : IDLE;
                    last_n  = oth_cyc ? !last : last;
                    cnt_n   = oth_cyc ? 8'h0 : cnt;
                end else
                    cnt_n = bus.i_s_ack ? 8'h0 : (cur_stb != 4'h0 ? cnt + 8'd1 : cnt);
            DROP:
                state_n = cur_cyc ? DROP : IDLE;
        endcase
    end
endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: directed checks of grant order, handover, routing, timeout and async reset.
module tb_wb_arbiter2;
    logic i_clk = 1'b0;
    logic i_reset = 1'b0;
    int vectors = 0;
    int errs = 0;
    wb_arbiter2_if #(.AW(32)) b();
    wb_arbiter2 #(.TIMEOUT_CYCLES(4), .AW(32)) dut (.i_clk(i_clk), .i_reset(i_reset), .bus(b.master));
    always #5 i_clk = ~i_clk;
    task automatic step;
        @(posedge i_clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask
    initial begin
        {b.i_m0_cyc, b.i_m1_cyc, b.i_m0_we, b.i_m1_we, b.i_s_ack} = '0;
        {b.i_m0_stb, b.i_m1_stb} = '0;
        {b.i_m0_addr, b.i_m1_addr, b.i_m0_dat, b.i_m1_dat, b.i_s_dat} = '0;
        step;
        step;
        chk("rst_s_cyc", 32'(b.o_s_cyc), 0);
        chk("rst_timeout", 32'(b.o_timeout), 0);
        chk("rst_m0_ack", 32'(b.o_m0_ack), 0);
        i_reset = 1'b1;
        // single master write, slave acks one cycle after grant
        b.i_m0_cyc = 1; b.i_m0_stb = 4'hF; b.i_m0_we = 1; b.i_m0_addr = 32'h10; b.i_m0_dat = 32'hDEADBEEF;
        step;
        chk("wr_s_cyc", 32'(b.o_s_cyc), 1);
        chk("wr_s_addr", b.o_s_addr, 32'h10);
        chk("wr_s_dat", b.o_s_dat, 32'hDEADBEEF);
        chk("wr_s_we", 32'(b.o_s_we), 1);
        chk("wr_s_stb", 32'(b.o_s_stb), 32'hF);
        b.i_s_ack = 1; #1;
        chk("wr_m0_ack", 32'(b.o_m0_ack), 1);
        chk("wr_m1_ack", 32'(b.o_m1_ack), 0);
        step;
        b.i_s_ack = 0; b.i_m0_cyc = 0; b.i_m0_stb = 0; b.i_m0_we = 0; #1;
        chk("wr_m0_ack_end", 32'(b.o_m0_ack), 0);
        step;
        chk("wr_idle_s_cyc", 32'(b.o_s_cyc), 0);
        chk("wr_idle_s_addr", b.o_s_addr, 0);
        chk("wr_idle_s_dat", b.o_s_dat, 0);
        // simultaneous requests straight out of reset
        i_reset = 0; #2; i_reset = 1;
        b.i_m0_addr = 32'h100; b.i_m1_addr = 32'h200;
        b.i_m0_cyc = 1; b.i_m1_cyc = 1; b.i_m0_stb = 4'hF; b.i_m1_stb = 4'hF;
        step;
        chk("tie_first_m0", b.o_s_addr, 32'h100);
        b.i_m0_cyc = 0; b.i_m0_stb = 0;
        step;
        chk("tie_handover_cyc", 32'(b.o_s_cyc), 1);
        chk("tie_handover_m1", b.o_s_addr, 32'h200);
        b.i_m1_cyc = 0;
        step;
        chk("tie_idle", 32'(b.o_s_cyc), 0);
        // round robin: last=1 so m0 first, then strict alternation
        b.i_m0_cyc = 1; b.i_m0_stb = 4'hF;
        b.i_m1_cyc = 1;
        step;
        for (int f = 0; f < 8; f++) begin
            chk("rr_owner", b.o_s_addr, (f % 2 == 0) ? 32'h100 : 32'h200);
            b.i_s_ack = 1; #1;
            chk("rr_ack", {30'h0, b.o_m1_ack, b.o_m0_ack}, (f % 2 == 0) ? 32'h1 : 32'h2);
            step;
            b.i_s_ack = 0;
            if (f % 2 == 0) b.i_m0_cyc = 0; else b.i_m1_cyc = 0;
            step;
            b.i_m0_cyc = 1; b.i_m1_cyc = 1;
        end
        b.i_m0_cyc = 0; b.i_m1_cyc = 0; b.i_m0_stb = 0; b.i_m1_stb = 0;
        step;
        chk("rr_idle", 32'(b.o_s_cyc), 0);
        // read routing to m1
        b.i_m1_cyc = 1; b.i_m1_stb = 4'hF; b.i_m1_addr = 32'h20;
        step;
        chk("rd_s_addr", b.o_s_addr, 32'h20);
        b.i_s_dat = 32'h12345678; b.i_s_ack = 1; #1;
        chk("rd_m1_dat", b.o_m1_dat, 32'h12345678);
        chk("rd_m1_ack", 32'(b.o_m1_ack), 1);
        chk("rd_m0_dat", b.o_m0_dat, 0);
        chk("rd_m0_ack", 32'(b.o_m0_ack), 0);
        step;
        b.i_s_ack = 0; b.i_m1_cyc = 0; b.i_m1_stb = 0; #1;
        chk("rd_m0_dat_after", b.o_m0_dat, 0);
        step;
        chk("rd_idle_m1_dat", b.o_m1_dat, 0);
        b.i_s_dat = 0;
        // timeout with TIMEOUT_CYCLES=4: err in the fifth cycle after the grant edge
        b.i_m0_cyc = 1; b.i_m0_stb = 4'hF; b.i_m0_addr = 32'h40;
        step;
        for (int c = 0; c < 4; c++) begin
            chk("to_no_err", 32'(b.o_m0_err), 0);
            chk("to_s_cyc", 32'(b.o_s_cyc), 1);
            step;
        end
        chk("to_err_pulse", 32'(b.o_m0_err), 1);
        chk("to_m1_err", 32'(b.o_m1_err), 0);
        chk("to_flag_pending", 32'(b.o_timeout), 0);
        step;
        chk("to_err_end", 32'(b.o_m0_err), 0);
        chk("to_flag", 32'(b.o_timeout), 1);
        chk("to_drop_cyc", 32'(b.o_s_cyc), 0);
        b.i_s_ack = 1; #1;
        chk("to_late_ack", 32'(b.o_m0_ack), 0);
        step;
        b.i_s_ack = 0;
        chk("to_drop_hold", 32'(b.o_s_cyc), 0);
        b.i_m0_cyc = 0; b.i_m0_stb = 0;
        step;
        chk("to_idle_cyc", 32'(b.o_s_cyc), 0);
        chk("to_sticky", 32'(b.o_timeout), 1);
        // async reset in the middle of an m1 access
        b.i_m1_cyc = 1; b.i_m1_stb = 4'hF; b.i_m1_addr = 32'h80;
        step;
        chk("rm_own1", b.o_s_addr, 32'h80);
        b.i_s_ack = 1; #1;
        i_reset = 0; #1;
        chk("rm_s_cyc", 32'(b.o_s_cyc), 0);
        chk("rm_s_addr", b.o_s_addr, 0);
        chk("rm_m1_ack", 32'(b.o_m1_ack), 0);
        chk("rm_timeout", 32'(b.o_timeout), 0);
        b.i_s_ack = 0;
        b.i_m0_cyc = 1; b.i_m0_stb = 4'hF; b.i_m0_addr = 32'h100;
        step;
        i_reset = 1;
        step;
        chk("rm_tie_m0", b.o_s_addr, 32'h100);
        b.i_m0_cyc = 0; b.i_m1_cyc = 0;
        step;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/wb_arbiter2.md
# wb_arbiter2

Two-master, one-slave Wishbone arbiter that shares the on-chip word RAM between the UART debug bridge (master 0) and a second bus master such as a CPU core (master 1). It grants the bus round-robin per cycle-frame (`cyc` high), routes the slave's ack and read data to the owner only, and enforces a bus timeout that returns an error to a master whose access is never acknowledged. It sits between the masters and the RAM write/read logic in the top level.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255. Number of cycles without a slave ack before a timeout is raised. Valid range is 1..255.
- `AW`, default 32. Address width.

Ports (clock and reset first):
- `i_clk` in 1: the single clock. All logic is on the rising edge.
- `i_reset` in 1: asynchronous, active-low reset.
- `i_m0_cyc`, `i_m1_cyc` in 1 each: master bus-cycle request.
- `i_m0_stb`, `i_m1_stb` in 4 each: byte strobes. Any nonzero value marks an access.
- `i_m0_we`, `i_m1_we` in 1 each: write enable.
- `i_m0_addr`, `i_m1_addr` in AW each: address.
- `i_m0_dat`, `i_m1_dat` in 32 each: write data.
- `o_m0_dat`, `o_m1_dat` out 32 each: read data.
- `o_m0_ack`, `o_m1_ack` out 1 each: acknowledge.
- `o_m0_err`, `o_m1_err` out 1 each: timeout error, a one-cycle pulse.
- `o_s_cyc` out 1, `o_s_stb` out 4, `o_s_we` out 1, `o_s_addr` out AW, `o_s_dat` out 32: slave request signals.
- `i_s_dat` in 32, `i_s_ack` in 1: slave response.
- `o_timeout` out 1: sticky flag, set by any timeout, cleared only by reset.

## Operation
States:
- IDLE: no owner.
- OWN0: master 0 owns the bus.
- OWN1: master 1 owns the bus.
- DROP: a timeout has occurred; the arbiter waits for the owner to release `cyc`.

Register `last` records the most recently granted master. Its reset value is 1, so master 0 wins the first tie.

IDLE transitions:
- Only m0 requests: go to OWN0.
- Only m1 requests: go to OWN1.
- Both request: grant the master that is not `last`.
- On every grant, set `last` to the granted master.

OWN*x* behaviour:
- The slave outputs mirror master *x* combinationally.
- `o_mx_ack` = `i_s_ack`.
- `o_mx_dat` = `i_s_dat`.
- Both outputs of the non-owner are held at 0.

OWN*x* transitions, when `i_mx_cyc` falls:
- If the other master's `cyc` is high, go directly to OWN(other) in the next cycle and update `last`. There is no idle bubble.
- Otherwise go to IDLE.

Slave outputs outside OWN states:
- In IDLE and DROP, all `o_s_*` outputs are 0.
- `o_s_addr` and `o_s_dat` are also 0 there, for deterministic traces.

Timeout counter:
- 8 bits wide.
- Cleared on grant and on any cycle with `i_s_ack` high in OWN.
- Increments each OWN cycle in which the owner's `stb` is nonzero and `i_s_ack` is low.
- When it reaches TIMEOUT_CYCLES:
  - pulse `o_mx_err` for one cycle (the cycle after the count is reached);
  - set `o_timeout`;
  - go to DROP.

DROP state:
- `o_s_cyc` is 0 and no ack is forwarded.
- Exit to IDLE once the owner's `cyc` is low.
- A late `i_s_ack` arriving in DROP is discarded.

Ownership rules:
- Owner holding `cyc` with `stb` = 0 (idle within a frame): it keeps the bus and the counter holds.
- A master cannot be preempted while its `cyc` stays high, except by timeout.

## Timing
- Grant latency: `cyc` sampled high in IDLE at edge N makes the slave outputs reflect that master from cycle N+1.
- Ack and read-data path from slave to owner is combinational, with 0 added cycles.
- The slave-output mux is combinational on the registered state.
- Handover: owner drops `cyc` in cycle N; the other master is driving the slave in cycle N+1.
- Reset (`i_reset` low, asynchronous) sets:
  - state = IDLE, `last` = 1, counter = 0, `o_timeout` = 0;
  - all outputs to 0.
  - Reset asserted mid-transfer aborts the transfer immediately. No ack or err is issued.
- Simultaneous ack and timeout in the same cycle: the ack wins and the counter clears.
- `o_mx_err` and `o_mx_ack` are never high together.

## Test plan
- **Single master write.** Reset, then m0 `cyc`=1, `stb`=4'hF, `we`=1, `addr`=0x10, `dat`=0xDEADBEEF, and the slave acks 1 cycle later.
  - Required: `o_s_addr`=0x10 and `o_s_dat`=0xDEADBEEF from cycle N+1.
  - Required: `o_m0_ack` pulses; `o_m1_ack` stays 0.
- **Simultaneous requests from reset.** Both `cyc` rise together, with m1 holding `cyc` high throughout.
  - Required: m0 is granted first.
  - Required: when m0 drops `cyc`, m1 is granted the next cycle with no IDLE cycle.
- **Round-robin fairness.** Both masters request continuously, each dropping `cyc` after one acked access.
  - Required: grants alternate 0,1,0,1 over 8 frames.
- **Read routing.** m1 reads `addr`=0x20 while the slave returns 0x12345678 with an ack.
  - Required: `o_m1_dat`=0x12345678.
  - Required: `o_m0_dat`=0 throughout.
- **Timeout.** `TIMEOUT_CYCLES`=4; m0 strobes and the slave never acks.
  - Required: `o_m0_err` is a one-cycle pulse 5 cycles after grant, and `o_timeout`=1.
  - Required: `o_s_cyc`=0 until m0 drops `cyc`.
  - Required: a late ack in DROP produces no `o_m0_ack`.
- **Reset mid-transfer.** Assert `i_reset` low asynchronously during OWN1.
  - Required: all outputs are 0 immediately.
  - Required: after release, a tie grants m0.
